// File: rtl/core_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : core_bus_arbiter_pkg
// Purpose: Shared definitions for the core bus arbiter. Holds the default bus
//          widths, the instruction opcode constants (including NOP) and the
//          arbiter state encoding.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package core_bus_arbiter_pkg;

  // Default core bus widths
  localparam int CORE_INSTR_W = 8;
  localparam int CORE_ADDR_W  = 24;
  localparam int CORE_DATA_W  = 32;

  // Instruction opcodes seen on the core bus
  localparam logic [CORE_INSTR_W-1:0] OP_NOP   = 8'h00;
  localparam logic [CORE_INSTR_W-1:0] OP_READ  = 8'h01;
  localparam logic [CORE_INSTR_W-1:0] OP_WRITE = 8'h02;

  // Arbiter state encoding
  localparam int ARB_ST_W = 2;
  localparam logic [ARB_ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ARB_ST_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [ARB_ST_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [ARB_ST_W-1:0] ST_DONE  = 2'd3;

  // Index width for a vector of n requesters (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_bus_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module : rr_priority_picker
// Purpose: Combinational round-robin picker. Returns the first set request
//          bit scanning last+1, last+2, ... modulo N.
// Ports  : req_i   [N]     request vector
//          last_i  [IDX_W] index granted most recently (lowest priority)
//          valid_o         at least one request is set
//          idx_o   [IDX_W] chosen requester index
// Rev    : 1.0  initial release
// ============================================================================
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  int               sum;
  logic [IDX_W-1:0] pos;

  // Scan from the farthest candidate to the nearest so the nearest set bit
  // after last_i is the one left in idx_o.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = 0;
    pos     = '0;
    for (int k = N; k >= 1; k--) begin
      sum = int'(last_i) + k;
      if (sum >= N) begin
        sum = sum - N;
      end
      pos = IDX_W'(sum);
      if (req_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : core_bus_arbiter
// Purpose: Round-robin arbiter sharing the internal core bus between NUM_REQ
//          requesters. One transaction in flight, fixed result latency, NOP
//          driven on the bus whenever idle.
// Ports  : clk_i, rst_i (async, active high)
//          req_i / req_instruction_i / req_address_i / req_value_i  requests
//          ack_o, rsp_result_o, grant_id_o, busy_o                  responses
//          instruction_o / address_o / value_o / result_i           core bus
// Rev    : 1.0  initial release
// ============================================================================
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int                 NUM_REQ        = 4,
  parameter int                 INSTR_W        = CORE_INSTR_W,
  parameter int                 ADDR_W         = CORE_ADDR_W,
  parameter int                 DATA_W         = CORE_DATA_W,
  parameter int                 RESULT_LATENCY = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR      = INSTR_W'(OP_NOP)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*INSTR_W-1:0]  req_instruction_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_value_i,
  output logic [NUM_REQ-1:0]          ack_o,
  output logic [DATA_W-1:0]           rsp_result_o,
  output logic [idx_width(NUM_REQ)-1:0] grant_id_o,
  output logic                        busy_o,
  output logic [INSTR_W-1:0]          instruction_o,
  output logic [ADDR_W-1:0]           address_o,
  output logic [DATA_W-1:0]           value_o,
  input  logic [DATA_W-1:0]           result_i
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(RESULT_LATENCY) + 1;

  logic [ARB_ST_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rsp_q, rsp_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   val_q, val_d;

  logic                w_pick_valid;
  logic [IDX_W-1:0]    w_pick_idx;
  logic [INSTR_W-1:0]  w_instr [NUM_REQ];
  logic [ADDR_W-1:0]   w_addr  [NUM_REQ];
  logic [DATA_W-1:0]   w_val   [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_instr[k] = req_instruction_i[k*INSTR_W +: INSTR_W];
    assign w_addr[k]  = req_address_i[k*ADDR_W +: ADDR_W];
    assign w_val[k]   = req_value_i[k*DATA_W +: DATA_W];
  end

  rr_priority_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (req_i),
    .last_i  (last_q),
    .valid_o (w_pick_valid),
    .idx_o   (w_pick_idx)
  );

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      rsp_q   <= '0;
      instr_q <= NOP_INSTR;
      addr_q  <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      rsp_q   <= rsp_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (w_pick_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered-output next values. ack is a single-cycle pulse, so it
  // defaults to zero; everything else holds unless the state updates it.
  always_comb begin
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ack_d   = '0;
    rsp_d   = rsp_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    val_d   = val_q;
    case (state_q)
      ST_IDLE: begin
        if (w_pick_valid) begin
          grant_d = w_pick_idx;
          instr_d = w_instr[w_pick_idx];
          addr_d  = w_addr[w_pick_idx];
          val_d   = w_val[w_pick_idx];
          busy_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        cnt_d = CNT_W'(RESULT_LATENCY - 1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_d = result_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        ack_d[grant_q] = 1'b1;
        last_d  = grant_q;
        instr_d = NOP_INSTR;
        addr_d  = '0;
        val_d   = '0;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  assign ack_o         = ack_q;
  assign rsp_result_o  = rsp_q;
  assign grant_id_o    = grant_q;
  assign busy_o        = busy_q;
  assign instruction_o = instr_q;
  assign address_o     = addr_q;
  assign value_o       = val_q;

endmodule
`default_nettype wire

// File: tb/tb_core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_core_bus_arbiter
// Purpose: Self-checking bench for core_bus_arbiter. Directed scenarios plus a
//          randomized phase checked against a behavioural round-robin model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_core_bus_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_i;
  logic [N*8-1:0]    req_instruction_i;
  logic [N*24-1:0]   req_address_i;
  logic [N*32-1:0]   req_value_i;
  logic [N-1:0]      ack_o;
  logic [31:0]       rsp_result_o;
  logic [1:0]        grant_id_o;
  logic              busy_o;
  logic [7:0]        instruction_o;
  logic [23:0]       address_o;
  logic [31:0]       value_o;
  logic [31:0]       result_i;

  core_bus_arbiter #(
    .NUM_REQ        (N),
    .RESULT_LATENCY (LAT)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_i             (req_i),
    .req_instruction_i (req_instruction_i),
    .req_address_i     (req_address_i),
    .req_value_i       (req_value_i),
    .ack_o             (ack_o),
    .rsp_result_o      (rsp_result_o),
    .grant_id_o        (grant_id_o),
    .busy_o            (busy_o),
    .instruction_o     (instruction_o),
    .address_o         (address_o),
    .value_o           (value_o),
    .result_i          (result_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] req_mask;
  logic [7:0]   f_instr [N];
  logic [23:0]  f_addr  [N];
  logic [31:0]  f_value [N];
  int           model_last;
  int           order [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply();
    req_i = req_mask;
    for (int k = 0; k < N; k++) begin
      req_instruction_i[k*8 +: 8]   = f_instr[k];
      req_address_i[k*24 +: 24]     = f_addr[k];
      req_value_i[k*32 +: 32]       = f_value[k];
    end
  endtask

  task automatic rand_fields(input int k);
    f_instr[k] = 8'($urandom_range(1, 255));
    f_addr[k]  = 24'($urandom);
    f_value[k] = $urandom;
  endtask

  // Round-robin reference: first pending requester after 'last', wrapping.
  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int s = 1; s <= N; s++) begin
      if (m[(last + s) % N]) return (last + s) % N;
    end
    return -1;
  endfunction

  // One transaction, starting with requests applied and arbiter idle.
  // The core-bus model presents 'res' only in the cycle LAT after issue.
  task automatic txn(input int id, input logic [31:0] res,
                     input bit chg_val, input bit drop);
    logic [7:0]  ei;
    logic [23:0] ea;
    logic [31:0] ev;
    logic [N-1:0] ack_exp;
    ei = f_instr[id];
    ea = f_addr[id];
    ev = f_value[id];
    ack_exp = '0;
    ack_exp[id] = 1'b1;
    tick();
    chk("grant_id", 64'(grant_id_o), 64'(id));
    chk("busy_issue", 64'(busy_o), 64'd1);
    chk("instr_issue", 64'(instruction_o), 64'(ei));
    chk("addr_issue", 64'(address_o), 64'(ea));
    chk("value_issue", 64'(value_o), 64'(ev));
    chk("ack_early", 64'(ack_o), 64'd0);
    result_i = (LAT == 1) ? res : $urandom;
    if (drop) begin
      req_mask[id] = 1'b0;
      apply();
    end
    for (int e = 2; e <= LAT + 2; e++) begin
      tick();
      if (e == 2 && chg_val) begin
        f_value[id] = 32'h22;
        apply();
      end
      chk("instr_hold", 64'(instruction_o), 64'(ei));
      chk("addr_hold", 64'(address_o), 64'(ea));
      chk("value_hold", 64'(value_o), 64'(ev));
      chk("busy_hold", 64'(busy_o), 64'd1);
      chk("ack_early", 64'(ack_o), 64'd0);
      result_i = (e == 1 + LAT) ? res : $urandom;
    end
    chk("rsp_capture", 64'(rsp_result_o), 64'(res));
    tick();
    chk("ack_pulse", 64'(ack_o), 64'(ack_exp));
    chk("busy_done", 64'(busy_o), 64'd0);
    chk("instr_nop", 64'(instruction_o), 64'h00);
    chk("addr_zero", 64'(address_o), 64'd0);
    chk("value_zero", 64'(value_o), 64'd0);
    chk("rsp_done", 64'(rsp_result_o), 64'(res));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, 64'(ack_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_rsp"}, 64'(rsp_result_o), 64'd0);
    chk({tag, "_grant"}, 64'(grant_id_o), 64'd0);
    chk({tag, "_instr"}, 64'(instruction_o), 64'h00);
    chk({tag, "_addr"}, 64'(address_o), 64'd0);
    chk({tag, "_value"}, 64'(value_o), 64'd0);
  endtask

  initial begin
    int id;
    rst_i    = 1'b1;
    req_mask = '0;
    result_i = '0;
    for (int k = 0; k < N; k++) rand_fields(k);
    apply();

    // Reset state
    tick();
    tick();
    chk_reset_vals("reset");
    rst_i = 1'b0;
    model_last = N - 1;

    // Single request from requester 1
    f_instr[1] = 8'h01;
    f_addr[1]  = 24'h000001;
    f_value[1] = 32'h0000_00AA;
    req_mask   = 4'b0010;
    apply();
    txn(1, 32'h1234_5678, 1'b0, 1'b0);
    model_last = 1;
    req_mask   = '0;
    apply();

    // Idle for 20 cycles
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_instr", 64'(instruction_o), 64'h00);
      chk("idle_ack", 64'(ack_o), 64'd0);
      chk("idle_busy", 64'(busy_o), 64'd0);
      chk("idle_rsp", 64'(rsp_result_o), 64'h1234_5678);
    end

    // Requester 2 changes its value during WAIT
    f_value[2] = 32'h11;
    req_mask   = 4'b0100;
    apply();
    txn(2, $urandom, 1'b1, 1'b0);
    model_last = 2;
    req_mask   = '0;

    // Requester 1 drops its request after grant; requester 2 pending
    rand_fields(1);
    rand_fields(2);
    req_mask = 4'b0110;
    apply();
    txn(1, $urandom, 1'b0, 1'b1);
    txn(2, $urandom, 1'b0, 1'b0);
    model_last = 2;
    req_mask   = '0;
    apply();
    tick();

    // Reset asserted during WAIT
    req_mask = 4'b1111;
    apply();
    tick();
    tick();
    tick();
    #2 rst_i = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    chk("midrst_noack", 64'(ack_o), 64'd0);
    rst_i = 1'b0;
    model_last = N - 1;

    // All four requesting continuously from reset
    for (int i = 0; i < 5; i++) begin
      txn(order[i], $urandom, 1'b0, 1'b0);
    end
    model_last = 0;
    req_mask   = '0;
    apply();

    // Randomized phase against the round-robin model
    for (int t = 0; t < 30; t++) begin
      req_mask = req_mask | 4'($urandom);
      if (req_mask == '0) req_mask[$urandom_range(0, N - 1)] = 1'b1;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 1) == 1) rand_fields(k);
      end
      apply();
      id = rr_pick(req_mask, model_last);
      txn(id, $urandom, 1'b0, 1'b0);
      model_last   = id;
      req_mask[id] = 1'b0;
    end
    req_mask = '0;
    apply();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
